// File: rtl/heu_pkg.sv
// Shared types and constants for the histogram-equalisation unit.
package heu_pkg;

  typedef enum logic [2:0] {IDLE, HIST, CDF, MAP, DONE} heu_state_t;

  typedef logic [7:0] pixel_t;

  localparam int GROUPS    = 5;
  localparam int GSIZE     = 80;
  localparam int NPIX      = GROUPS * GSIZE;
  localparam int HIST_BINS = 256;
  localparam int BIN_W     = 9;
  localparam int K_SCALE   = 41780;
  localparam int GRP_W     = $clog2(GROUPS);
  localparam int IDX_W     = $clog2(GSIZE);

  // Scaled CDF lookup: (cdf*K)>>16 saturated to a pixel.
  function automatic pixel_t scale_cdf(input logic [BIN_W-1:0] cdf);
    logic [24:0] prod;
    prod = 25'(cdf) * 25'(K_SCALE);
    return (prod[24:16] > 9'd255) ? 8'hFF : prod[23:16];
  endfunction

endpackage

// File: rtl/heu_if.sv
// Window handshake between bcau, heu and dnn.
interface heu_if
  import heu_pkg::*;
();

  logic   bcau_valid;
  pixel_t bcau_results [GROUPS][GSIZE];
  logic   heu_ready;
  logic   dnn_ready;
  logic   heu_valid;
  pixel_t heu_results [GROUPS][GSIZE];

  modport master (
    output bcau_valid, bcau_results, dnn_ready,
    input  heu_ready, heu_valid, heu_results
  );

  modport slave (
    input  bcau_valid, bcau_results, dnn_ready,
    output heu_ready, heu_valid, heu_results
  );

endinterface

// File: rtl/heu_hist_ram.sv
// 256x9 bin store with one R/W port; holds the histogram, then the CDF in place.
module heu_hist_ram
  import heu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic             load,
  input  logic [7:0]       addr,
  input  logic [BIN_W-1:0] wdata,
  output logic [BIN_W-1:0] rdata
);

  logic [BIN_W-1:0] mem [HIST_BINS];

  assign rdata = mem[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (clear) begin
      mem <= '{default: '0};
    end else if (inc) begin
      mem[addr] <= mem[addr] + 9'd1;
    end else if (load) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/heu.sv
// Histogram-equalisation unit: capture window, histogram, CDF, remap, hand to dnn.
module heu
  import heu_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  heu_if.slave bus
);

  heu_state_t       state;
  logic [GRP_W-1:0] grp;
  logic [IDX_W-1:0] idx;
  logic [7:0]       bin;
  logic [BIN_W-1:0] acc;
  logic             ready_q;
  logic             valid_q;
  pixel_t           in_buf  [GROUPS][GSIZE];
  pixel_t           out_buf [GROUPS][GSIZE];

  logic             ram_clear;
  logic             ram_inc;
  logic             ram_load;
  logic [7:0]       ram_addr;
  logic [BIN_W-1:0] ram_rdata;
  logic [BIN_W-1:0] cdf_sum;
  logic             last_pix;
  logic             capture;

  assign capture  = (state == IDLE) && bus.bcau_valid;
  assign last_pix = (grp == GRP_W'(GROUPS - 1)) && (idx == IDX_W'(GSIZE - 1));
  assign cdf_sum  = acc + ram_rdata;

  // Pixel passes address the bins by pixel value; the CDF pass walks the bins.
  always_comb begin
    ram_clear = 1'b0;
    ram_inc   = 1'b0;
    ram_load  = 1'b0;
    ram_addr  = in_buf[grp][idx];
    case (state)
      IDLE:    ram_clear = bus.bcau_valid;
      HIST:    ram_inc   = 1'b1;
      CDF: begin
        ram_load = 1'b1;
        ram_addr = bin;
      end
      default: ;
    endcase
  end

  heu_hist_ram u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ram_clear),
    .inc   (ram_inc),
    .load  (ram_load),
    .addr  (ram_addr),
    .wdata (cdf_sum),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      in_buf <= bus.bcau_results;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grp     <= '0;
      idx     <= '0;
      bin     <= '0;
      acc     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      out_buf <= '{default: '0};
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bcau_valid) begin
            ready_q <= 1'b1;
            grp     <= '0;
            idx     <= '0;
            state   <= HIST;
          end
        end
        HIST: begin
          if (last_pix) begin
            grp   <= '0;
            idx   <= '0;
            bin   <= '0;
            acc   <= '0;
            state <= CDF;
          end else if (idx == IDX_W'(GSIZE - 1)) begin
            idx <= '0;
            grp <= grp + GRP_W'(1);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        CDF: begin
          acc <= cdf_sum;
          bin <= bin + 8'd1;
          if (bin == 8'hFF) begin
            state <= MAP;
          end
        end
        MAP: begin
          out_buf[grp][idx] <= scale_cdf(ram_rdata);
          if (last_pix) begin
            grp     <= '0;
            idx     <= '0;
            valid_q <= 1'b1;
            state   <= DONE;
          end else if (idx == IDX_W'(GSIZE - 1)) begin
            idx <= '0;
            grp <= grp + GRP_W'(1);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.dnn_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.heu_ready   = ready_q;
  assign bus.heu_valid   = valid_q;
  assign bus.heu_results = out_buf;

endmodule

// File: tb/tb_heu.sv
// Self-checking bench for heu against a behavioural histogram-equalisation model.
module tb_heu;
  import heu_pkg::*;

  localparam int TB_NPIX  = 400;
  localparam int TB_K     = 41780;
  localparam int LATENCY  = 1056;
  localparam int CLK_PER  = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  heu_if bus();

  heu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #(CLK_PER / 2) clk = ~clk;

  bit   m_busy;
  bit   m_done;
  int   m_age;
  logic m_ready;
  logic m_valid;
  int   m_pend [TB_NPIX];
  int   m_out  [TB_NPIX];
  int   cap_px [TB_NPIX];
  int   win    [TB_NPIX];
  int   zeros  [TB_NPIX];

  function automatic void equalise(input int px [TB_NPIX], output int eo [TB_NPIX]);
    int hist [256];
    int cdf  [256];
    int run;
    foreach (hist[b]) hist[b] = 0;
    foreach (px[i]) hist[px[i]]++;
    run = 0;
    for (int b = 0; b < 256; b++) begin
      run    += hist[b];
      cdf[b] = run;
    end
    foreach (px[i]) begin
      eo[i] = (cdf[px[i]] * TB_K) / 65536;
      if (eo[i] > 255) eo[i] = 255;
    end
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkWindow(input string name, input int exp [TB_NPIX]);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 80; k++)
        if (int'(bus.heu_results[j][k]) != exp[j*80+k]) begin
          bad++;
          if (first < 0) first = j*80 + k;
        end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL %s %0d pixels differ, first p=%0d got %0d expected %0d at %0t",
               name, bad, first, bus.heu_results[first/80][first%80], exp[first], $time);
    end
  endtask

  // Transaction-level model: capture, fixed latency, hold until dnn takes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_age   = 0;
      m_ready = 1'b0;
      m_valid = 1'b0;
      foreach (m_out[i]) m_out[i] = 0;
    end else begin
      m_ready = 1'b0;
      if (m_done) begin
        if (bus.dnn_ready) begin
          m_done  = 1'b0;
          m_valid = 1'b0;
        end
      end else if (m_busy) begin
        m_age++;
        if (m_age == LATENCY) begin
          m_busy  = 1'b0;
          m_done  = 1'b1;
          m_valid = 1'b1;
          m_out   = m_pend;
        end
      end else if (bus.bcau_valid) begin
        for (int j = 0; j < 5; j++)
          for (int k = 0; k < 80; k++)
            cap_px[j*80+k] = int'(bus.bcau_results[j][k]);
        equalise(cap_px, m_pend);
        m_busy  = 1'b1;
        m_age   = 0;
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("heu_ready", bus.heu_ready, m_ready);
      checkOutput("heu_valid", bus.heu_valid, m_valid);
      if (m_valid) checkWindow("heu_results", m_out);
    end
  end

  task automatic drivePattern();
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 80; k++)
        bus.bcau_results[j][k] = 8'(win[j*80+k]);
  endtask

  task automatic applyStimulus(input bit hold, output time t_rdy);
    int n;
    @(posedge clk);
    #2;
    drivePattern();
    bus.bcau_valid = 1'b1;
    n = 0;
    while (!bus.heu_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    t_rdy = $time;
    checkOutput("capture_timeout", int'(bus.heu_ready), 1);
    if (!hold) begin
      @(posedge clk);
      #2;
      bus.bcau_valid = 1'b0;
    end
  endtask

  task automatic waitValid(output time t_val);
    int n;
    n = 0;
    while (!bus.heu_valid && n < 10000) begin
      @(negedge clk);
      n++;
    end
    t_val = $time;
    checkOutput("valid_timeout", int'(bus.heu_valid), 1);
  endtask

  task automatic releaseWindow();
    @(posedge clk);
    #2;
    bus.dnn_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("valid_drop", bus.heu_valid, 0);
    #1;
    bus.dnn_ready = 1'b0;
  endtask

  task automatic randomWindow();
    int lo;
    int span;
    lo   = int'($urandom_range(255, 0));
    span = int'($urandom_range(255, 0));
    foreach (win[i]) begin
      if ($urandom_range(2, 0) == 0) win[i] = int'($urandom_range(255, 0));
      else win[i] = (lo + int'($urandom_range(span, 0))) % 256;
    end
  endtask

  initial begin
    time t_rdy;
    time t_val;
    time t_rdy2;
    int  eo [TB_NPIX];
    int  snap [TB_NPIX];
    int  n;
    bit  ready_seen;

    foreach (zeros[i]) zeros[i] = 0;
    bus.bcau_valid = 1'b0;
    bus.dnn_ready  = 1'b0;
    foreach (win[i]) win[i] = 0;
    drivePattern();

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_valid", bus.heu_valid, 0);
    checkOutput("reset_ready", bus.heu_ready, 0);
    checkWindow("reset_results", zeros);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Model pins: half-dark/half-bright and uniform windows.
    foreach (win[i]) win[i] = (i < 200) ? 0 : 255;
    equalise(win, eo);
    checkOutput("model_dark", eo[0], 127);
    checkOutput("model_bright", eo[399], 255);
    foreach (win[i]) win[i] = 100;
    equalise(win, eo);
    checkOutput("model_uniform", eo[17], 255);

    $display("[TB] uniform window");
    applyStimulus(1'b0, t_rdy);
    waitValid(t_val);
    checkOutput("t1_latency", int'((t_val - t_rdy) / CLK_PER), LATENCY);
    checkOutput("t1_out_first", bus.heu_results[0][0], 255);
    checkOutput("t1_out_last", bus.heu_results[4][79], 255);
    releaseWindow();

    $display("[TB] split window");
    foreach (win[i]) win[i] = (i < 200) ? 0 : 255;
    applyStimulus(1'b0, t_rdy);
    waitValid(t_val);
    checkOutput("t2_p0", bus.heu_results[0][0], 127);
    checkOutput("t2_p199", bus.heu_results[2][39], 127);
    checkOutput("t2_p200", bus.heu_results[2][40], 255);
    checkOutput("t2_p399", bus.heu_results[4][79], 255);
    releaseWindow();

    $display("[TB] random windows");
    for (int w = 0; w < 10; w++) begin
      randomWindow();
      applyStimulus(1'b0, t_rdy);
      waitValid(t_val);
      releaseWindow();
    end

    $display("[TB] hold in DONE");
    randomWindow();
    applyStimulus(1'b0, t_rdy);
    waitValid(t_val);
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 80; k++)
        snap[j*80+k] = int'(bus.heu_results[j][k]);
    @(posedge clk);
    #2;
    randomWindow();
    drivePattern();
    bus.bcau_valid = 1'b1;
    ready_seen = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (bus.heu_ready) ready_seen = 1'b1;
    end
    checkOutput("t4_valid_held", bus.heu_valid, 1);
    checkOutput("t4_no_ready", int'(ready_seen), 0);
    checkWindow("t4_results_held", snap);
    @(posedge clk);
    #2;
    bus.bcau_valid = 1'b0;
    releaseWindow();

    $display("[TB] reset mid-histogram");
    randomWindow();
    applyStimulus(1'b0, t_rdy);
    repeat (149) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_valid", bus.heu_valid, 0);
    checkOutput("t5_ready", bus.heu_ready, 0);
    checkWindow("t5_results", zeros);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    randomWindow();
    applyStimulus(1'b0, t_rdy);
    waitValid(t_val);
    releaseWindow();

    $display("[TB] back-to-back");
    bus.dnn_ready = 1'b1;
    randomWindow();
    applyStimulus(1'b1, t_rdy);
    randomWindow();
    drivePattern();
    waitValid(t_val);
    n = 0;
    while (!bus.heu_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    t_rdy2 = $time;
    checkOutput("t6_recapture_gap", n, 2);
    @(posedge clk);
    #2;
    bus.bcau_valid = 1'b0;
    waitValid(t_val);
    checkOutput("t6_latency", int'((t_val - t_rdy2) / CLK_PER), LATENCY);
    @(posedge clk);
    #1;
    checkOutput("t6_valid_drop", bus.heu_valid, 0);
    #1;
    bus.dnn_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(60000 * CLK_PER);
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
